conv2d_seq_mac: RTL and testbench



---
 rtl/conv2d_seq_mac.sv | 258 +++++++++++++++++++++++++
 tb/tb_conv2d_seq_mac.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_seq_mac.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : conv2d_seq_mac                                                |
// | Description : Time-multiplexed 2-D convolution engine. A single signed     |
// |               MAC computes one output word at a time (INIT, M taps, WRITE) |
// |               with bias preload, Q-format rounding toward -inf,            |
// |               saturation to DATA_WIDTH and optional ReLU.                  |
// | Ports       : clk                 rising-edge clock                        |
// |               rst                 asynchronous active-low reset            |
// |               start               run request, sampled only in IDLE        |
// |               busy                high while words are being produced      |
// |               done                one-cycle pulse after the last WRITE     |
// |               input_tensor_flat   (b,c,h,w) at ((b*IC+c)*H+h)*W+w          |
// |               weights_flat        (o,c,kh,kw) at ((o*IC+c)*K+kh)*K+kw      |
// |               bias_flat           bias of channel o at word o              |
// |               output_tensor_flat  (b,o,y,x) at ((b*OC+o)*OH+y)*OW+x, reg'd |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module conv2d_seq_mac #(
  parameter int BATCH_SIZE   = 1,
  parameter int IN_CHANNELS  = 2,
  parameter int OUT_CHANNELS = 1,
  parameter int IN_HEIGHT    = 4,
  parameter int IN_WIDTH     = 4,
  parameter int KERNEL_SIZE  = 3,
  parameter int STRIDE       = 1,
  parameter int PADDING      = 1,
  parameter int DATA_WIDTH   = 32,
  parameter int FRAC_BITS    = 16,
  parameter int RELU_EN      = 0,
  localparam int c_OH = (IN_HEIGHT + 2*PADDING - KERNEL_SIZE) / STRIDE + 1,
  localparam int c_OW = (IN_WIDTH  + 2*PADDING - KERNEL_SIZE) / STRIDE + 1,
  localparam int c_N  = BATCH_SIZE * OUT_CHANNELS * c_OH * c_OW
) (
  input  logic                                                              clk,
  input  logic                                                              rst,
  input  logic                                                              start,
  output logic                                                              busy,
  output logic                                                              done,
  input  logic [BATCH_SIZE*IN_CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH-1:0]   input_tensor_flat,
  input  logic [OUT_CHANNELS*IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] weights_flat,
  input  logic [OUT_CHANNELS*DATA_WIDTH-1:0]                                bias_flat,
  output logic [c_N*DATA_WIDTH-1:0]                                         output_tensor_flat
);

  function automatic int f_cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int c_M   = IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE;
  // Sized so that M full-scale products plus the bias cannot wrap.
  localparam int c_AW  = 2*DATA_WIDTH + $clog2(c_M) + 1;
  localparam int c_BW  = f_cw(BATCH_SIZE);
  localparam int c_OCW = f_cw(OUT_CHANNELS);
  localparam int c_YW  = f_cw(c_OH);
  localparam int c_XW  = f_cw(c_OW);
  localparam int c_CW  = f_cw(IN_CHANNELS);
  localparam int c_KW  = f_cw(KERNEL_SIZE);
  localparam int c_NW  = f_cw(c_N);

  localparam logic signed [c_AW-1:0] c_SAT_MAX = {{(c_AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [c_AW-1:0] c_SAT_MIN = {{(c_AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_MAC   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [c_BW-1:0]         b_q,  b_d;
  logic [c_OCW-1:0]        o_q,  o_d;
  logic [c_YW-1:0]         y_q,  y_d;
  logic [c_XW-1:0]         x_q,  x_d;
  logic [c_CW-1:0]         c_q,  c_d;
  logic [c_KW-1:0]         kh_q, kh_d;
  logic [c_KW-1:0]         kw_q, kw_d;
  logic [c_NW-1:0]         idx_q, idx_d;
  logic signed [c_AW-1:0]  acc_q, acc_d;
  logic [c_N*DATA_WIDTH-1:0] out_q;
  logic                    w_wr_en;

  // Tap addressing and product
  int                            w_ih, w_iw, w_in_idx, w_wt_idx;
  logic                          w_in_ok;
  logic [DATA_WIDTH-1:0]         w_in_word, w_wt_word, w_bias_word;
  logic signed [2*DATA_WIDTH-1:0] w_in_ext, w_wt_ext, w_prod;
  logic signed [c_AW-1:0]        w_prod_ext, w_bias_ext;

  always_comb begin
    w_ih     = int'(y_q) * STRIDE + int'(kh_q) - PADDING;
    w_iw     = int'(x_q) * STRIDE + int'(kw_q) - PADDING;
    w_in_ok  = (w_ih >= 0) && (w_ih < IN_HEIGHT) && (w_iw >= 0) && (w_iw < IN_WIDTH);
    // Padding taps still read a legal word; the product is forced to zero below.
    w_in_idx = 0;
    if (w_in_ok) begin
      w_in_idx = ((int'(b_q) * IN_CHANNELS + int'(c_q)) * IN_HEIGHT + w_ih) * IN_WIDTH + w_iw;
    end
    w_wt_idx = ((int'(o_q) * IN_CHANNELS + int'(c_q)) * KERNEL_SIZE + int'(kh_q)) * KERNEL_SIZE
               + int'(kw_q);
    w_in_word   = input_tensor_flat[w_in_idx*DATA_WIDTH +: DATA_WIDTH];
    w_wt_word   = weights_flat[w_wt_idx*DATA_WIDTH +: DATA_WIDTH];
    w_bias_word = bias_flat[int'(o_q)*DATA_WIDTH +: DATA_WIDTH];

    w_in_ext   = {{DATA_WIDTH{w_in_word[DATA_WIDTH-1]}}, w_in_word};
    w_wt_ext   = {{DATA_WIDTH{w_wt_word[DATA_WIDTH-1]}}, w_wt_word};
    w_prod     = w_in_ok ? (w_in_ext * w_wt_ext) : '0;
    w_prod_ext = {{(c_AW-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};
    w_bias_ext = {{(c_AW-DATA_WIDTH){w_bias_word[DATA_WIDTH-1]}}, w_bias_word};
  end

  // Requantisation: floor shift, saturate, optional ReLU
  logic signed [c_AW-1:0] w_shr, w_sat;
  logic [DATA_WIDTH-1:0]  w_res;

  always_comb begin
    w_shr = acc_q >>> FRAC_BITS;
    w_sat = w_shr;
    if (w_shr > c_SAT_MAX) begin
      w_sat = c_SAT_MAX;
    end else if (w_shr < c_SAT_MIN) begin
      w_sat = c_SAT_MIN;
    end
    w_res = w_sat[DATA_WIDTH-1:0];
    if ((RELU_EN != 0) && w_sat[DATA_WIDTH-1]) begin
      w_res = '0;
    end
  end

  // Next-state logic
  logic w_last_tap, w_last_out;

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    o_d     = o_q;
    y_d     = y_q;
    x_d     = x_q;
    c_d     = c_q;
    kh_d    = kh_q;
    kw_d    = kw_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    w_wr_en = 1'b0;

    w_last_tap = (int'(c_q) == IN_CHANNELS-1) && (int'(kh_q) == KERNEL_SIZE-1)
                 && (int'(kw_q) == KERNEL_SIZE-1);
    w_last_out = (int'(idx_q) == c_N-1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT;
        end
      end

      S_INIT: begin
        acc_d   = w_bias_ext <<< FRAC_BITS;
        state_d = S_MAC;
      end

      S_MAC: begin
        acc_d = acc_q + w_prod_ext;
        // kw fastest, then kh, then c; all wrap to zero after the last tap
        if (int'(kw_q) == KERNEL_SIZE-1) begin
          kw_d = '0;
          if (int'(kh_q) == KERNEL_SIZE-1) begin
            kh_d = '0;
            if (int'(c_q) == IN_CHANNELS-1) c_d = '0;
            else                            c_d = c_q + 1'b1;
          end else begin
            kh_d = kh_q + 1'b1;
          end
        end else begin
          kw_d = kw_q + 1'b1;
        end
        if (w_last_tap) begin
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        w_wr_en = 1'b1;
        idx_d   = w_last_out ? '0 : idx_q + 1'b1;
        // x fastest, then y, o, b; everything is back at zero after the last word
        if (int'(x_q) == c_OW-1) begin
          x_d = '0;
          if (int'(y_q) == c_OH-1) begin
            y_d = '0;
            if (int'(o_q) == OUT_CHANNELS-1) begin
              o_d = '0;
              if (int'(b_q) == BATCH_SIZE-1) b_d = '0;
              else                           b_d = b_q + 1'b1;
            end else begin
              o_d = o_q + 1'b1;
            end
          end else begin
            y_d = y_q + 1'b1;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
        state_d = w_last_out ? S_DONE : S_INIT;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      b_q     <= '0;
      o_q     <= '0;
      y_q     <= '0;
      x_q     <= '0;
      c_q     <= '0;
      kh_q    <= '0;
      kw_q    <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      o_q     <= o_d;
      y_q     <= y_d;
      x_q     <= x_d;
      c_q     <= c_d;
      kh_q    <= kh_d;
      kw_q    <= kw_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

  // Only the addressed word changes; the rest keep their previous contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
    end else if (w_wr_en) begin
      out_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] <= w_res;
    end
  end

  assign busy               = (state_q == S_INIT) || (state_q == S_MAC) || (state_q == S_WRITE);
  assign done               = (state_q == S_DONE);
  assign output_tensor_flat = out_q;

endmodule
`default_nettype wire

// File: tb/tb_conv2d_seq_mac.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_conv2d_seq_mac                                             |
// | Description : Scoreboard bench for conv2d_seq_mac. Three instances:        |
// |               default, default with ReLU, and K=5/S=2/P=2 on 8x8.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_conv2d_seq_mac;

  typedef struct {
    logic [1023:0] exp;
    int            t0;
    int            nw;
    int            cyc_done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Default and ReLU instances share the data buses
  logic          m_start = 1'b0, m_busy, m_done;
  logic          r_start = 1'b0, r_busy, r_done;
  logic [1023:0] in_a   = '0;
  logic [575:0]  wt_a   = '0;
  logic [31:0]   bias_a = '0;
  logic [511:0]  m_out, r_out;

  logic          k_start = 1'b0, k_busy, k_done;
  logic [2047:0] in_k   = '0;
  logic [1599:0] wt_k   = '0;
  logic [63:0]   bias_k = '0;
  logic [1023:0] k_out;

  conv2d_seq_mac u_main (
    .clk(clk), .rst(rst), .start(m_start), .busy(m_busy), .done(m_done),
    .input_tensor_flat(in_a), .weights_flat(wt_a), .bias_flat(bias_a),
    .output_tensor_flat(m_out)
  );

  conv2d_seq_mac #(.RELU_EN(1)) u_relu (
    .clk(clk), .rst(rst), .start(r_start), .busy(r_busy), .done(r_done),
    .input_tensor_flat(in_a), .weights_flat(wt_a), .bias_flat(bias_a),
    .output_tensor_flat(r_out)
  );

  conv2d_seq_mac #(
    .IN_CHANNELS(1), .OUT_CHANNELS(2), .IN_HEIGHT(8), .IN_WIDTH(8),
    .KERNEL_SIZE(5), .STRIDE(2), .PADDING(2)
  ) u_k5 (
    .clk(clk), .rst(rst), .start(k_start), .busy(k_busy), .done(k_done),
    .input_tensor_flat(in_k), .weights_flat(wt_k), .bias_flat(bias_k),
    .output_tensor_flat(k_out)
  );

  exp_t qm[$];
  exp_t qr[$];
  exp_t qk[$];
  int   bad_m = 0, bad_r = 0, bad_k = 0;
  int   n_done_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic finish_run(input string tag, input exp_t e, input int rel, input int bad,
                            input logic [1023:0] act);
    chk({tag, "_done_cycle"}, rel, e.cyc_done);
    chk({tag, "_busy_window_errors"}, bad, 0);
    for (int i = 0; i < e.nw; i++) begin
      chk($sformatf("%s_word%0d", tag, i), act[i*32 +: 32], e.exp[i*32 +: 32]);
    end
  endtask

  task automatic unexpected(input string tag);
    n_checks++;
    n_fail++;
    $display("FAIL %s_unexpected_done: got done=1 at cycle %0d, expected no pending run", tag, cyc);
  endtask

  // Monitors: busy must be high exactly in cycles 1..cyc_done-1 of the run
  always @(negedge clk) begin
    exp_t e;
    if (qm.size() != 0) begin
      if (m_busy !== ((cyc - qm[0].t0) >= 1 && (cyc - qm[0].t0) < qm[0].cyc_done)) bad_m++;
    end
    if (m_done === 1'b1) begin
      n_done_m++;
      if (qm.size() == 0) unexpected("main");
      else begin
        e = qm.pop_front();
        finish_run("main", e, cyc - e.t0, bad_m, {512'b0, m_out});
        bad_m = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (qr.size() != 0) begin
      if (r_busy !== ((cyc - qr[0].t0) >= 1 && (cyc - qr[0].t0) < qr[0].cyc_done)) bad_r++;
    end
    if (r_done === 1'b1) begin
      if (qr.size() == 0) unexpected("relu");
      else begin
        e = qr.pop_front();
        finish_run("relu", e, cyc - e.t0, bad_r, {512'b0, r_out});
        bad_r = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (qk.size() != 0) begin
      if (k_busy !== ((cyc - qk[0].t0) >= 1 && (cyc - qk[0].t0) < qk[0].cyc_done)) bad_k++;
    end
    if (k_done === 1'b1) begin
      if (qk.size() == 0) unexpected("k5");
      else begin
        e = qk.pop_front();
        finish_run("k5", e, cyc - e.t0, bad_k, k_out);
        bad_k = 0;
      end
    end
  end

  function automatic logic [31:0] q16(input int v);
    return 32'(v * 65536);
  endfunction

  // Valid 3x3/pad-1 taps along one axis of a 4-wide map: 2 at the border, 3 inside.
  function automatic exp_t exp_default(input int bias_units, input bit relu);
    exp_t e;
    int   taps4[4];
    int   v;
    taps4 = '{2, 3, 3, 2};
    e.exp = '0;
    e.nw = 16;
    e.cyc_done = 321;
    e.t0 = 0;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++) begin
        v = taps4[y] * taps4[x] * 2 + bias_units;
        if (relu && v < 0) v = 0;
        e.exp[(y*4 + x)*32 +: 32] = q16(v);
      end
    end
    return e;
  endfunction

  function automatic exp_t exp_const(input logic [31:0] w);
    exp_t e;
    e.exp = '0;
    e.nw = 16;
    e.cyc_done = 321;
    e.t0 = 0;
    for (int i = 0; i < 16; i++) e.exp[i*32 +: 32] = w;
    return e;
  endfunction

  // Unit-weight 5x5 window sum of input value h*8+w; word 0 is rows/cols 0..2 = 81.
  function automatic exp_t exp_k5();
    exp_t e;
    int   s, h, w;
    e.exp = '0;
    e.nw = 32;
    e.cyc_done = 32 * 27 + 1;
    e.t0 = 0;
    for (int o = 0; o < 2; o++) begin
      for (int y = 0; y < 4; y++) begin
        for (int x = 0; x < 4; x++) begin
          s = 0;
          for (int kh = 0; kh < 5; kh++) begin
            for (int kw = 0; kw < 5; kw++) begin
              h = y*2 + kh - 2;
              w = x*2 + kw - 2;
              if (h >= 0 && h < 8 && w >= 0 && w < 8) s += h*8 + w;
            end
          end
          e.exp[((o*4 + y)*4 + x)*32 +: 32] = q16(s);
        end
      end
    end
    return e;
  endfunction

  function automatic int pending();
    return qm.size() + qr.size() + qk.size();
  endfunction

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (pending() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (pending() != 0) begin
      n_fail++;
      $display("FAIL run_timeout: got %0d runs pending after %0d cycles, expected 0", pending(), limit);
      qm.delete();
      qr.delete();
      qk.delete();
    end
  endtask

  task automatic launch_main(input exp_t e);
    e.t0 = cyc;
    qm.push_back(e);
    m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
  endtask

  task automatic set_ab(input logic [31:0] iv, input logic [31:0] wv, input logic [31:0] bv);
    for (int i = 0; i < 32; i++) in_a[i*32 +: 32] = iv;
    for (int i = 0; i < 18; i++) wt_a[i*32 +: 32] = wv;
    bias_a = bv;
  endtask

  initial begin
    exp_t e;
    int   dn0;

    repeat (3) @(negedge clk);
    chk("reset_busy", {31'b0, m_busy}, 0);
    chk("reset_done", {31'b0, m_done}, 0);
    chk("reset_out_main_nonzero", {31'b0, |m_out}, 0);
    chk("reset_out_k5_nonzero", {31'b0, |k_out}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // All ones: corners 8.0, edges 12.0, interior 18.0
    set_ab(32'h0001_0000, 32'h0001_0000, 32'h0);
    launch_main(exp_default(0, 1'b0));
    wait_idle(2000);

    // Bias -20.0 on both the plain and the ReLU instance
    set_ab(32'h0001_0000, 32'h0001_0000, 32'hFFEC_0000);
    @(negedge clk);
    e = exp_default(-20, 1'b0);
    e.t0 = cyc;
    qm.push_back(e);
    e = exp_default(-20, 1'b1);
    e.t0 = cyc;
    qr.push_back(e);
    m_start = 1'b1;
    r_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    r_start = 1'b0;
    wait_idle(2000);

    // Saturation both ways
    set_ab(32'h7FFF_0000, 32'h7FFF_0000, 32'h0);
    @(negedge clk);
    launch_main(exp_const(32'h7FFF_FFFF));
    wait_idle(2000);
    set_ab(32'h7FFF_0000, 32'h8001_0000, 32'h0);
    @(negedge clk);
    launch_main(exp_const(32'h8000_0000));
    wait_idle(2000);

    // start hammered while busy: no restart, done still at 321
    set_ab(32'h0001_0000, 32'h0001_0000, 32'h0);
    @(negedge clk);
    e = exp_default(0, 1'b0);
    e.t0 = cyc;
    qm.push_back(e);
    m_start = 1'b1;
    for (int i = 1; i <= 320; i++) begin
      @(negedge clk);
      m_start = (i % 4 == 0);
    end
    @(negedge clk);
    m_start = 1'b0;
    wait_idle(100);
    repeat (4) @(negedge clk);
    chk("spam_busy_after_done", {31'b0, m_busy}, 0);

    // Reset mid-run at cycle 150
    @(negedge clk);
    dn0 = n_done_m;
    launch_main(exp_default(0, 1'b0));
    repeat (149) @(negedge clk);
    qm.delete();
    rst = 1'b0;
    #1;
    chk("abort_busy", {31'b0, m_busy}, 0);
    chk("abort_done", {31'b0, m_done}, 0);
    chk("abort_out_nonzero", {31'b0, |m_out}, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (400) @(negedge clk);
    chk("abort_done_pulses", n_done_m - dn0, 0);
    launch_main(exp_default(0, 1'b0));
    wait_idle(2000);

    // K=5, S=2, P=2 on 8x8, two identical output channels
    for (int i = 0; i < 64; i++) in_k[i*32 +: 32] = q16(i);
    for (int i = 0; i < 50; i++) wt_k[i*32 +: 32] = 32'h0001_0000;
    bias_k = '0;
    @(negedge clk);
    e = exp_k5();
    e.t0 = cyc;
    qk.push_back(e);
    k_start = 1'b1;
    @(negedge clk);
    k_start = 1'b0;
    wait_idle(2000);
    chk("k5_word0_hand", k_out[31:0], 32'h0051_0000);
    chk("k5_ch1_eq_ch0_word5", k_out[(16+5)*32 +: 32], q16(5*8 + 15*0 + 0) + q16(0) + 32'h0 + exp_k5_word5());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Channel-0 word 5 is (y=1,x=1): rows 0..4, cols 0..4 -> sum = 5*(0+1+2+3+4) + 5*8*(0+1+2+3+4) = 450.
  // Expected channel-1 word 5 equals that same 450.0; the first three terms above add 40.0.
  function automatic logic [31:0] exp_k5_word5();
    return q16(450 - 40);
  endfunction

endmodule
`default_nettype wire
